// File: rtl/aob_uart_tx.sv
// rtl/aob_uart_tx.sv - byte FIFO feeding an 8N1 UART transmitter behind the CPU output bus
module aob_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          wr_i,
    input  logic [7:0]                    data_i,
    input  logic                          clr_ovf_i,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic                          empty_o,
    output logic                          full_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          ovf_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            ovf_q, ovf_d;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            baud_last;

    // Fullness and emptiness are judged on pre-edge state, so a drop happens
    // even when a pop lands on the same edge, and a fresh byte is never popped
    // on the edge that writes it.
    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign push      = wr_i & ~full;
    assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                tx_d   = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when more data waits.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (wr_i && full) begin
            ovf_d = 1'b1;
        end else if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign tx_o    = tx_q;
    assign busy_o  = (state_q != IDLE);
    assign empty_o = empty;
    assign full_o  = full;
    assign count_o = count_q;
    assign ovf_o   = ovf_q;

endmodule

// File: doc/aob_uart_tx.md
Name: aob_uart_tx

Overview:
- Output-side peripheral directly downstream of the CPU's 8-bit output bus (aob_o).
- Captures each byte the CPU writes and queues it in a small FIFO.
- Serializes queued bytes onto a UART line: 8N1, LSB first, fixed baud divider.
- Gives the CPU/bench status (full/empty/busy/count) and a sticky overflow flag.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per UART bit (>=2; 4 for simulation).
- FIFO_DEPTH, 8, FIFO entries (power of 2, >=2).

Ports:
- clk_i  input  1  system clock, rising edge
- rst_i  input  1  asynchronous reset, active-high
- wr_i  input  1  write strobe; byte on data_i is pushed at the rising edge when wr_i=1
- data_i  input  8  byte to transmit (driven from CPU aob_o)
- clr_ovf_i  input  1  clears ovf_o
- tx_o  output  1  UART serial out, idle high
- busy_o  output  1  transmitter not in IDLE
- empty_o  output  1  FIFO holds 0 entries
- full_o  output  1  FIFO holds FIFO_DEPTH entries
- count_o  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- ovf_o  output  1  sticky: a write was dropped

Behaviour:
- Clocking and reset: one clock (clk_i). rst_i is asynchronous, active-high.
- Reset (immediate, asynchronous): tx_o=1, busy_o=0, empty_o=1, full_o=0, count_o=0, ovf_o=0.
  - FIFO pointers are zeroed; FSM goes to IDLE; bit and baud counters are zeroed.
  - Reset mid-frame aborts the frame; tx_o returns high with no glitch low.
- FIFO:
  - Push when wr_i=1 and full_o=0 at the sampling edge.
  - wr_i=1 while full_o=1 drops the byte and sets ovf_o. This holds even if a pop occurs on the same edge; fullness is judged on pre-edge state.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo FIFO_DEPTH.
  - A byte pushed into an empty FIFO cannot be popped on the same edge.
- ovf_o:
  - Set on a dropped write; cleared by clr_ovf_i.
  - Set wins over clear on the same edge.
- FSM states: IDLE, START, DATA, STOP. All outputs are registered.
  - IDLE: tx_o=1. If empty_o=0 at an edge: pop the head into the shift register, tx_o<=0, go to START.
  - START: hold tx_o=0 for CLKS_PER_BIT cycles. Then tx_o<=bit0 and go to DATA.
  - DATA: each bit is held CLKS_PER_BIT cycles, LSB first. The bit index counts 0..7; after bit7's period, tx_o<=1 and go to STOP.
  - STOP: hold tx_o=1 for CLKS_PER_BIT cycles. At the end of the period:
    - FIFO non-empty: pop, tx_o<=0, go to START (no idle gap).
    - Otherwise: go to IDLE.
- Frame timing:
  - A frame is exactly 10*CLKS_PER_BIT cycles.
  - Latency: a write into an empty FIFO with the FSM in IDLE gives tx_o low at the next rising edge after the write edge.
- busy_o = (state != IDLE).
- Status outputs: count_o, empty_o and full_o are updated at the same edge as the push/pop they reflect.
- data_i is ignored when wr_i=0.

Test Plan:
- Single byte (CLKS_PER_BIT=4): wr_i=1, data_i=0xA5 for one cycle.
  - tx_o goes low one edge later, then holds each level 4 cycles: 0,1,0,1,0,0,1,0,1,1 (start, b0..b7, stop).
  - busy_o is high for exactly 40 cycles, then returns to 0; empty_o=1 throughout after the pop.
- Back-to-back: write 0x01 then 0x80 on consecutive cycles.
  - Second start bit falls exactly 40 cycles after the first.
  - tx_o never idles high between the frames beyond the stop bit.
  - Second frame data = 0,0,0,0,0,0,0,1 (LSB first).
- Fill/overflow: 10 consecutive writes (0x00..0x09) from idle.
  - 0x00 is popped at the second edge.
  - After the 9th write: count_o=8, full_o=1, ovf_o=0.
  - 10th write (0x09) is dropped and ovf_o=1.
  - Serial output sequence is 0x00..0x08 only.
- Overflow clear:
  - clr_ovf_i=1 alone clears ovf_o at the next edge.
  - clr_ovf_i=1 on the same edge as a dropped write leaves ovf_o=1.
- Reset mid-frame:
  - Assert rst_i during DATA bit3 of 0x55 with 3 bytes queued. tx_o=1, count_o=0, empty_o=1, busy_o=0 immediately (before the next edge).
  - After release, a new write of 0x3C transmits a clean full frame.
- Wrap-around:
  - Write 6 bytes, let all transmit, then write 6 more (pointers wrap past index 7).
  - All 12 bytes appear on tx_o in order; count_o returns to 0.
